// File: rtl/register_dump_sequencer.sv
// Streams every register of the processor register file out as bytes, MSB first,
// over a valid/ready byte channel. Built for NB=32 (four bytes per register).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; index held at 0
// LATCH | capture the addressed register into the shift register
// SEND  | offer shift[31:24]; shift left one byte per transfer
// NEXT  | last byte of a register sent; advance index or finish
// DONE  | one-cycle completion pulse, index returns to 0
module register_dump_sequencer #(
    parameter int NB      = 32,
    parameter int REGS    = 5,
    parameter int NB_BYTE = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_abort,
    output logic [REGS-1:0]     o_mips_register_number,
    input  logic [NB-1:0]       i_mips_register_data,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        SEND  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [REGS-1:0] IDX_ONE   = {{(REGS-1){1'b0}}, 1'b1};
    localparam logic [REGS-1:0] IDX_LAST  = {REGS{1'b1}};
    localparam logic [1:0]      BYTE_LAST = 2'd3;

    state_t            state_q, state_nxt;
    logic [REGS-1:0]   idx_q, idx_nxt;
    logic [1:0]        cnt_q, cnt_nxt;
    logic [NB-1:0]     shift_q, shift_nxt;
    logic              xfer;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            cnt_q   <= cnt_nxt;
            shift_q <= shift_nxt;
        end
    end

    assign xfer = (state_q == SEND) && i_tx_ready;

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        shift_nxt = shift_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_nxt = LATCH;
                    idx_nxt   = '0;
                end
            end
            LATCH: begin
                shift_nxt = i_mips_register_data;
                cnt_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: begin
                if (xfer) begin
                    shift_nxt = {shift_q[NB-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                    cnt_nxt   = cnt_q + 2'd1;
                    if (cnt_q == BYTE_LAST) begin
                        state_nxt = NEXT;
                    end
                end
            end
            NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx_q + IDX_ONE;
                    state_nxt = LATCH;
                end
            end
            DONE: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides any transition, even one that coincides with a transfer.
        if (i_abort && (state_q != IDLE)) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end
    end

    assign o_mips_register_number = idx_q;
    assign o_tx_data              = shift_q[NB-1 -: NB_BYTE];
    assign o_tx_valid             = (state_q == SEND);
    assign o_busy                 = (state_q != IDLE);
    assign o_done                 = (state_q == DONE);

endmodule

// File: tb/tb_register_dump_sequencer.sv
// Directed bench for register_dump_sequencer: full dumps, backpressure, abort,
// async reset mid-dump, spurious/held start.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_register_dump_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_abort;
    logic [4:0]  o_mips_register_number;
    logic [31:0] i_mips_register_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    int         done_cnt   = 0;
    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 i_clk = ~i_clk;

    // Register file model: regN = 0xA0B0C000 + N
    assign i_mips_register_data = 32'hA0B0C000 + {27'd0, o_mips_register_number};

    register_dump_sequencer #(.NB(32), .REGS(5), .NB_BYTE(8)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_start                (i_start),
        .i_abort                (i_abort),
        .o_mips_register_number (o_mips_register_number),
        .i_mips_register_data   (i_mips_register_data),
        .o_tx_data              (o_tx_data),
        .o_tx_valid             (o_tx_valid),
        .i_tx_ready             (i_tx_ready),
        .o_busy                 (o_busy),
        .o_done                 (o_done)
    );

    always @(posedge i_clk) begin
        if (i_reset) begin
            if (o_tx_valid && i_tx_ready) rx_q.push_back(o_tx_data);
            if (o_done) done_cnt++;
            if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stall_viol++;
            prev_stall = o_tx_valid && !i_tx_ready && !i_abort;
            prev_data  = o_tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        int         bad;
        logic [31:0] w;
        logic [7:0]  e;
        `CHK({tag, "_len"}, rx_q.size(), 128)
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 128; i++) begin
            w = 32'hA0B0C000 + 32'(i / 4);
            e = w[31 - 8 * (i % 4) -: 8];
            if (rx_q[i] !== e) bad++;
        end
        `CHK({tag, "_bytes"}, bad, 0)
    endtask

    task automatic full_dump(input string tag, input bit rand_ready);
        int cyc;
        int d0;
        rx_q.delete();
        d0 = done_cnt;
        stall_viol = 0;
        i_start = 1'b1;
        cyc = 0;
        do begin
            if (rand_ready) i_tx_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            i_start = 1'b0;
        end while (!o_done && cyc < 3000);
        `CHK({tag, "_done_seen"}, o_done, 1'b1)
        if (!rand_ready) `CHK({tag, "_done_cycle"}, cyc, 193)
        i_tx_ready = 1'b1;
        tick();
        check_stream(tag);
        `CHK({tag, "_done_once"}, done_cnt - d0, 1)
        `CHK({tag, "_busy_after"}, o_busy, 1'b0)
        `CHK({tag, "_stall_stable"}, stall_viol, 0)
    endtask

    initial begin
        int cyc;
        int d0;
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_tx_ready = 1'b1;
        #12;
        `CHK("rst_regnum", o_mips_register_number, 5'd0)
        `CHK("rst_txdata", o_tx_data, 8'h00)
        `CHK("rst_valid", o_tx_valid, 1'b0)
        `CHK("rst_busy", o_busy, 1'b0)
        `CHK("rst_done", o_done, 1'b0)
        tick();
        i_reset = 1'b1;
        tick();
        tick();
        `CHK("idle_busy", o_busy, 1'b0)

        full_dump("full", 1'b0);

        full_dump("bp", 1'b1);

        // start and abort together in IDLE: start wins
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        `CHK("startabort_busy", o_busy, 1'b1)
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        `CHK("abort_latch_busy", o_busy, 1'b0)

        // abort during SEND of register 5, byte 2
        rx_q.delete();
        d0 = done_cnt;
        i_start = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
            i_start = 1'b0;
        end while (rx_q.size() < 22 && cyc < 500);
        i_tx_ready = 1'b0;
        tick();
        `CHK("ab_regnum_pre", o_mips_register_number, 5'd5)
        `CHK("ab_data_pre", o_tx_data, 8'hC0)
        `CHK("ab_valid_pre", o_tx_valid, 1'b1)
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        i_tx_ready = 1'b1;
        `CHK("ab_valid", o_tx_valid, 1'b0)
        `CHK("ab_busy", o_busy, 1'b0)
        `CHK("ab_regnum", o_mips_register_number, 5'd0)
        for (int i = 0; i < 5; i++) tick();
        `CHK("ab_no_done", done_cnt - d0, 0)
        `CHK("ab_stays_idle", o_busy, 1'b0)

        // async reset mid-dump during register 17
        d0 = done_cnt;
        i_start = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
            i_start = 1'b0;
        end while (o_mips_register_number != 5'd17 && cyc < 500);
        tick();
        tick();
        `CHK("mr_busy_pre", o_busy, 1'b1)
        #3;
        i_reset = 1'b0;
        #1;
        `CHK("mr_regnum", o_mips_register_number, 5'd0)
        `CHK("mr_txdata", o_tx_data, 8'h00)
        `CHK("mr_valid", o_tx_valid, 1'b0)
        `CHK("mr_busy", o_busy, 1'b0)
        `CHK("mr_done", o_done, 1'b0)
        tick();
        i_reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        `CHK("mr_wait_idle", o_busy, 1'b0)
        `CHK("mr_no_done", done_cnt - d0, 0)
        full_dump("after_rst", 1'b0);

        // spurious start during register 10, then start held through DONE
        rx_q.delete();
        d0 = done_cnt;
        stall_viol = 0;
        i_start = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
            i_start = (cyc == 63 || cyc >= 185) ? 1'b1 : 1'b0;
            if (cyc == 63) `CHK("sp_regnum10", o_mips_register_number, 5'd10)
        end while (!o_done && cyc < 500);
        `CHK("sp_done_cycle", cyc, 193)
        check_stream("sp");
        rx_q.delete();
        tick();
        `CHK("sp_idle_after_done", o_busy, 1'b0)
        `CHK("sp_one_done", done_cnt - d0, 1)
        tick();
        i_start = 1'b0;
        `CHK("sp_restart_busy", o_busy, 1'b1)
        `CHK("sp_restart_regnum", o_mips_register_number, 5'd0)
        cyc = 0;
        while (!o_done && cyc < 500) begin
            tick();
            cyc++;
        end
        `CHK("sp2_done_cycle", cyc, 192)
        tick();
        check_stream("sp2");
        `CHK("sp2_done_total", done_cnt - d0, 2)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_dump_sequencer.md
REGISTER_DUMP_SEQUENCER -- requirements
Module: register_dump_sequencer

Interface
REQ-001 Parameter NB, default 32, register data width in bits; the block SHALL support only NB=32.
REQ-002 Parameter REGS, default 5, register-number width; the register count SHALL be 2**REGS (32).
REQ-003 Parameter NB_BYTE, default 8, transmit byte width.
REQ-004 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 i_start  input  1  dump request, sampled only in IDLE.
REQ-007 i_abort  input  1  synchronous cancel of a dump in progress.
REQ-008 o_mips_register_number  output  REGS  register-file debug read address.
REQ-009 i_mips_register_data  input  NB  register-file debug read data, combinational from o_mips_register_number.
REQ-010 o_tx_data  output  NB_BYTE  byte offered to the transmitter.
REQ-011 o_tx_valid  output  1  o_tx_data is valid.
REQ-012 i_tx_ready  input  1  transmitter accepts the byte; a transfer SHALL occur on any edge where o_tx_valid and i_tx_ready are both high.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_done  output  1  one-cycle pulse when a dump completes.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, LATCH, SEND, NEXT, DONE.
REQ-016 IDLE: if i_start=1, the next state SHALL be LATCH with register index 0; otherwise the FSM SHALL stay in IDLE.
REQ-017 LATCH (1 cycle): the block SHALL capture i_mips_register_data into a 32-bit shift register, clear the byte counter, and go to SEND.
REQ-018 SEND: o_tx_valid SHALL be 1 and o_tx_data SHALL be shift[31:24], so each register is sent MSB byte first.
REQ-019 SEND handshake:
- Each transfer SHALL shift the register left by 8 and increment the byte counter.
- The transfer with byte counter=3 SHALL move the FSM to NEXT.
REQ-020 SEND hold: o_tx_valid and o_tx_data SHALL stay stable while i_tx_ready=0; valid SHALL never drop before a transfer.
REQ-021 NEXT (1 cycle): if index=2**REGS-1, the FSM SHALL go to DONE; otherwise it SHALL increment the index and go to LATCH.
REQ-022 DONE (1 cycle): o_done SHALL be 1, the index SHALL return to 0, and the FSM SHALL go to IDLE.
REQ-023 o_mips_register_number SHALL equal the registered index at all times; the index SHALL change only at the NEXT, DONE, IDLE-start and abort transitions.
REQ-024 o_tx_valid SHALL be 0 in every state other than SEND.
REQ-025 Throughput: with i_tx_ready held at 1, each register SHALL take 6 cycles (LATCH + 4 SEND + NEXT), giving 128 bytes in 192 cycles.
REQ-026 With i_tx_ready held at 1, o_done SHALL assert in the 193rd cycle after the edge at which i_start was sampled.
REQ-027 i_start outside IDLE SHALL be ignored and SHALL NOT restart or extend the dump.
REQ-028 i_abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
- index cleared to 0;
- o_tx_valid cleared;
- o_done not pulsed.
REQ-029 If i_abort coincides with a SEND transfer, the transfer still counts at the transmitter, and abort SHALL still win the state transition.
REQ-030 If i_abort and i_start are both high in IDLE, i_start SHALL win and the dump SHALL begin.
REQ-031 i_start held high through DONE SHALL start a new dump on the first IDLE cycle after DONE, not in DONE itself.
REQ-032 Register 0 SHALL be read and sent like any other register; the block SHALL NOT special-case it.

Reset
REQ-033 Asserting i_reset low SHALL immediately force:
- state IDLE;
- index 0, byte counter 0, shift register 0;
- o_mips_register_number=0, o_tx_data=0x00, o_tx_valid=0, o_busy=0, o_done=0.
REQ-034 Reset asserted mid-dump SHALL abandon the dump with no o_done pulse; after release, the block SHALL wait in IDLE for a new i_start.

Verification
REQ-035 Full dump: registers preloaded with regN=0xA0B0C000+N, ready=1, start pulse -> 128 bytes A0,B0,C0,00,A0,B0,C0,01,...,A0,B0,C0,1F; o_done pulses exactly once, 193 cycles after start; o_busy is then 0.
REQ-036 Backpressure: ready toggled 1-0-0-1 pseudo-randomly -> byte sequence identical to REQ-035, and o_tx_data/o_tx_valid stable across every stall.
REQ-037 Abort: abort asserted during SEND of register 5, byte 2 -> o_tx_valid=0 and o_busy=0 the next cycle, no o_done, o_mips_register_number=0.
REQ-038 Reset mid-dump: i_reset driven low asynchronously between edges during register 17 -> all outputs at reset values before the next edge; a new start then dumps from register 0.
REQ-039 Spurious start: i_start pulsed during register 10 -> output stream unchanged and a single o_done; start held high through DONE -> a second dump begins one cycle after DONE.
